// File: rtl/controle_multiciclo.sv
// Main control FSM for the multicycle RV32I datapath: Moore-decoded selects and
// write enables per state, with the branch PC write qualified by Zero/funct3.
module controle_multiciclo (
   input  logic       clockCPU,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       Zero,
   input  logic [2:0] funct3,
   output logic [3:0] estado,
   output logic       EscrevePC,
   output logic       EscrevePCBack,
   output logic       EscreveIR,
   output logic       EscreveReg,
   output logic       EscreveMem,
   output logic       LeMem,
   output logic       IouD,
   output logic [1:0] OrigAULA,
   output logic [1:0] OrigBULA,
   output logic [1:0] ALUOp,
   output logic       OrigPC,
   output logic [1:0] Mem2Reg,
   output logic       ilegal
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADDR  = 4'd2,
      MEMREAD  = 4'd3,
      LOADWB   = 4'd4,
      MEMWRITE = 4'd5,
      EXEC_R   = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      JAL      = 4'd9,
      EXEC_I   = 4'd10,
      JALR     = 4'd11,
      LUI      = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   state_t state, state_next;

   // raw enables before the reset gate
   logic pc_we, pcback_we, ir_we, reg_we, mem_we;
   logic taken;

   always_ff @(posedge clockCPU) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   assign estado = state;

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_next = FETCH;
      pc_we      = 1'b0;
      pcback_we  = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      LeMem      = 1'b0;
      IouD       = 1'b0;
      OrigAULA   = 2'b00;
      OrigBULA   = 2'b00;
      ALUOp      = 2'b00;
      OrigPC     = 1'b0;
      Mem2Reg    = 2'b00;
      ilegal     = 1'b0;
      case (state)
         FETCH: begin
            LeMem      = 1'b1;
            ir_we      = 1'b1;
            pcback_we  = 1'b1;
            pc_we      = 1'b1;
            OrigBULA   = 2'b01;
            state_next = DECODE;
         end
         DECODE: begin
            // speculative PCBack+imm lands in ALUOut for branch/jal
            OrigAULA = 2'b10;
            OrigBULA = 2'b10;
            case (opcode)
               OP_LOAD, OP_STORE: state_next = MEMADDR;
               OP_R:              state_next = EXEC_R;
               OP_I:              state_next = EXEC_I;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               OP_JALR:           state_next = JALR;
               OP_LUI:            state_next = LUI;
               default: begin
                  ilegal     = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADDR: begin
            OrigAULA   = 2'b01;
            OrigBULA   = 2'b10;
            state_next = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            LeMem      = 1'b1;
            IouD       = 1'b1;
            state_next = LOADWB;
         end
         LOADWB: begin
            reg_we  = 1'b1;
            Mem2Reg = 2'b01;
         end
         MEMWRITE: begin
            mem_we = 1'b1;
            IouD   = 1'b1;
         end
         EXEC_R: begin
            OrigAULA   = 2'b01;
            ALUOp      = 2'b10;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_we = 1'b1;
         end
         BRANCH: begin
            OrigAULA = 2'b01;
            ALUOp    = 2'b01;
            OrigPC   = 1'b1;
            pc_we    = taken;
         end
         JAL: begin
            reg_we  = 1'b1;
            Mem2Reg = 2'b10;
            OrigPC  = 1'b1;
            pc_we   = 1'b1;
         end
         EXEC_I: begin
            OrigAULA   = 2'b01;
            OrigBULA   = 2'b10;
            ALUOp      = 2'b10;
            state_next = ALUWB;
         end
         JALR: begin
            // link reads PC before this edge's update, rs1 from latched regA
            OrigAULA = 2'b01;
            OrigBULA = 2'b10;
            pc_we    = 1'b1;
            reg_we   = 1'b1;
            Mem2Reg  = 2'b10;
         end
         LUI: begin
            reg_we  = 1'b1;
            Mem2Reg = 2'b11;
         end
         default: state_next = FETCH;
      endcase
   end

   assign EscrevePC     = pc_we     & ~reset;
   assign EscrevePCBack = pcback_we & ~reset;
   assign EscreveIR     = ir_we     & ~reset;
   assign EscreveReg    = reg_we    & ~reset;
   assign EscreveMem    = mem_we    & ~reset;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: expected output vectors per cycle
// are queued as each instruction is driven and compared on the falling edge.
module tb_controle_multiciclo;

   logic       clockCPU = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       Zero;
   logic [2:0] funct3;
   logic [3:0] estado;
   logic       EscrevePC, EscrevePCBack, EscreveIR, EscreveReg, EscreveMem;
   logic       LeMem, IouD, OrigPC, ilegal;
   logic [1:0] OrigAULA, OrigBULA, ALUOp, Mem2Reg;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [20:0] v;
   } exp_t;

   exp_t q[$];
   int   path[$];

   controle_multiciclo dut (
      .clockCPU(clockCPU), .reset(reset), .opcode(opcode), .Zero(Zero),
      .funct3(funct3), .estado(estado), .EscrevePC(EscrevePC),
      .EscrevePCBack(EscrevePCBack), .EscreveIR(EscreveIR),
      .EscreveReg(EscreveReg), .EscreveMem(EscreveMem), .LeMem(LeMem),
      .IouD(IouD), .OrigAULA(OrigAULA), .OrigBULA(OrigBULA), .ALUOp(ALUOp),
      .OrigPC(OrigPC), .Mem2Reg(Mem2Reg), .ilegal(ilegal)
   );

   always #5 clockCPU = ~clockCPU;

   // {estado, PC, PCBack, IR, Reg, Mem, LeMem, IouD, A, B, ALUOp, OrigPC, Mem2Reg, ilegal}
   function automatic logic [20:0] pack(input logic [3:0] st, input logic [6:0] en,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] op, input logic opc,
                                        input logic [1:0] m2r, input logic il);
      return {st, en, a, b, op, opc, m2r, il};
   endfunction

   // en bits: PC PCBack IR Reg Mem LeMem IouD
   function automatic logic [20:0] exp_vec(input int st, input logic [6:0] op,
                                           input logic [2:0] f3, input logic z,
                                           input logic rst);
      logic [20:0] v;
      logic        tk;
      tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
      case (st)
         0:  v = pack(4'd0,  7'b1110010, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
         1:  v = pack(4'd1,  7'b0000000, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00,
                      !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111}));
         2:  v = pack(4'd2,  7'b0000000, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
         3:  v = pack(4'd3,  7'b0000011, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
         4:  v = pack(4'd4,  7'b0001000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0);
         5:  v = pack(4'd5,  7'b0000101, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
         6:  v = pack(4'd6,  7'b0000000, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0);
         7:  v = pack(4'd7,  7'b0001000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
         8:  v = pack(4'd8,  {tk, 6'b000000}, 2'b01, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0);
         9:  v = pack(4'd9,  7'b1001000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0);
         10: v = pack(4'd10, 7'b0000000, 2'b01, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0);
         11: v = pack(4'd11, 7'b1001000, 2'b01, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0);
         12: v = pack(4'd12, 7'b0001000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0);
         default: v = '0;
      endcase
      if (rst) v[16:12] = 5'b00000;
      return v;
   endfunction

   function automatic logic [20:0] observed();
      return {estado, EscrevePC, EscrevePCBack, EscreveIR, EscreveReg, EscreveMem,
              LeMem, IouD, OrigAULA, OrigBULA, ALUOp, OrigPC, Mem2Reg, ilegal};
   endfunction

   task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%b exp=%b", tag, got, exp);
      end
   endtask

   // one queued expectation per cycle, compared before the next rising edge
   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(negedge clockCPU);
         chk(e.tag, observed(), e.v);
         @(posedge clockCPU);
         #1;
      end
   endtask

   task automatic run_instr(input string name, input logic [6:0] op,
                            input logic [2:0] f3, input logic z);
      opcode = op;
      funct3 = f3;
      Zero   = z;
      foreach (path[i])
         q.push_back('{$sformatf("%s.s%0d", name, path[i]), exp_vec(path[i], op, f3, z, 1'b0)});
      drain();
   endtask

   initial begin
      exp_t e;
      reset  = 1'b1;
      opcode = 7'd0;
      funct3 = 3'd0;
      Zero   = 1'b0;
      @(posedge clockCPU);
      @(posedge clockCPU);
      #1;
      @(negedge clockCPU);
      chk("reset_state", observed(), exp_vec(0, 7'd0, 3'd0, 1'b0, 1'b1));
      @(posedge clockCPU);
      #1;
      reset = 1'b0;

      path = '{0, 1, 6, 7};    run_instr("rtype", 7'b0110011, 3'b000, 1'b0);
      path = '{0, 1, 10, 7};   run_instr("itype", 7'b0010011, 3'b000, 1'b0);
      path = '{0, 1, 2, 3, 4}; run_instr("load",  7'b0000011, 3'b010, 1'b0);
      path = '{0, 1, 2, 5};    run_instr("store", 7'b0100011, 3'b010, 1'b0);
      path = '{0, 1, 8};       run_instr("beq_t", 7'b1100011, 3'b000, 1'b1);
      path = '{0, 1, 8};       run_instr("beq_n", 7'b1100011, 3'b000, 1'b0);
      path = '{0, 1, 8};       run_instr("bne_t", 7'b1100011, 3'b001, 1'b0);
      path = '{0, 1, 8};       run_instr("bne_n", 7'b1100011, 3'b001, 1'b1);
      path = '{0, 1, 8};       run_instr("blt_n", 7'b1100011, 3'b100, 1'b1);
      path = '{0, 1, 9};       run_instr("jal",   7'b1101111, 3'b000, 1'b0);
      path = '{0, 1, 11};      run_instr("jalr",  7'b1100111, 3'b000, 1'b0);
      path = '{0, 1, 12};      run_instr("lui",   7'b0110111, 3'b000, 1'b0);
      path = '{0, 1};          run_instr("ilg",   7'b1111111, 3'b000, 1'b0);
      path = '{0, 1};          run_instr("ilg0",  7'b0000000, 3'b000, 1'b0);

      // reset held two cycles while sitting in EXEC_R
      path = '{0, 1};          run_instr("rst_r", 7'b0110011, 3'b000, 1'b0);
      reset = 1'b1;
      q.push_back('{"rst_r.exec", exp_vec(6, opcode, funct3, Zero, 1'b1)});
      q.push_back('{"rst_r.hold1", exp_vec(0, opcode, funct3, Zero, 1'b1)});
      while (q.size() > 0) begin
         e = q.pop_front();
         @(negedge clockCPU);
         chk(e.tag, observed(), e.v);
         @(posedge clockCPU);
         #1;
      end
      reset = 1'b0;
      path = '{0, 1, 6, 7};    run_instr("after_rst", 7'b0110011, 3'b000, 1'b0);

      // reset landing on JAL must suppress its PC and register writes
      path = '{0, 1};          run_instr("rst_j", 7'b1101111, 3'b000, 1'b0);
      reset = 1'b1;
      q.push_back('{"rst_j.jal", exp_vec(9, opcode, funct3, Zero, 1'b1)});
      drain();
      reset = 1'b0;
      path = '{0, 1, 12};      run_instr("after_rstj", 7'b0110111, 3'b000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Main control FSM for the multicycle RV32I datapath. Sequences every instruction through fetch, decode, execute, memory and writeback states. Drives all Moore-decoded mux selects and write enables for the shared ALU, the unified instruction/data memory path (`IouD`), the IR, the PC/PCBack registers and the register file. Exports its state on `estado` for the board debug display.

## Interface
- No parameters; opcode map and state encoding are fixed below.
- `clockCPU` in 1: CPU clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; forces `estado` to FETCH on the next edge.
- `opcode` in 7: IR[6:0]; sampled only in DECODE and MEMADDR.
- `Zero` in 1: ALU zero flag; used only in BRANCH.
- `funct3` in 3: IR[14:12]; used only in BRANCH (000 beq: taken if `Zero`=1; 001 bne: taken if `Zero`=0; others: not taken).
- `estado` out 4: current state code.
- `EscrevePC`, `EscrevePCBack`, `EscreveIR`, `EscreveReg`, `EscreveMem`, `LeMem`, `IouD` out 1 each.
- `OrigAULA` out 2: 00 PC, 01 regA, 10 PCBack.
- `OrigBULA` out 2: 00 regB, 01 const 4, 10 imm.
- `ALUOp` out 2: 00 add, 01 sub, 10 decode by funct3/funct7.
- `OrigPC` out 1: 0 ALU result, 1 ALUOut register.
- `Mem2Reg` out 2: 00 ALUOut, 01 MDR, 10 PC, 11 imm.
- `ilegal` out 1: high in DECODE when `opcode` is unsupported.

## Operation
- The state register is the only storage. All outputs are combinational from `estado` (plus `Zero`/`funct3` in BRANCH). Unlisted outputs are 0.
- 0 FETCH: `LeMem`=1, `IouD`=0, `EscreveIR`=1, `EscrevePCBack`=1, `EscrevePC`=1, A=00, B=01, ALUOp=00, OrigPC=0. Next state: DECODE.
- 1 DECODE: A=10, B=10, ALUOp=00 (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 or 0100011: MEMADDR
  - 0110011: EXEC_R
  - 0010011: EXEC_I
  - 1100011: BRANCH
  - 1101111: JAL
  - 1100111: JALR
  - 0110111: LUI
  - else: FETCH with `ilegal`=1 and no write enables.
- 2 MEMADDR: A=01, B=10, ALUOp=00. Next: MEMREAD if opcode 0000011, else MEMWRITE.
- 3 MEMREAD: `LeMem`=1, `IouD`=1. Next: LOADWB.
- 4 LOADWB: `EscreveReg`=1, Mem2Reg=01. Next: FETCH.
- 5 MEMWRITE: `EscreveMem`=1, `IouD`=1. Next: FETCH.
- 6 EXEC_R: A=01, B=00, ALUOp=10. Next: ALUWB.
- 7 ALUWB: `EscreveReg`=1, Mem2Reg=00. Next: FETCH.
- 8 BRANCH: A=01, B=00, ALUOp=01, OrigPC=1. `EscrevePC` = taken (per `funct3` rule). Next: FETCH.
- 9 JAL: `EscreveReg`=1, Mem2Reg=10, OrigPC=1, `EscrevePC`=1. Next: FETCH.
- 10 EXEC_I: A=01, B=10, ALUOp=10. Next: ALUWB.
- 11 JALR: A=01, B=10, ALUOp=00, OrigPC=0, `EscrevePC`=1, `EscreveReg`=1, Mem2Reg=10. Next: FETCH. The link value comes from PC (already PC+4) before the update; rs1 comes from latched regA, so rd==rs1 is safe.
- 12 LUI: `EscreveReg`=1, Mem2Reg=11. Next: FETCH.
- Codes 13–15 are unreachable; if entered, all enables are 0 and next state is FETCH.

## Timing
- `reset`=1 at an edge: `estado`=0000 after that edge. While `reset`=1, every write enable (`EscrevePC`, `EscrevePCBack`, `EscreveIR`, `EscreveReg`, `EscreveMem`) is forced to 0 combinationally. Fetch starts on the first edge after `reset` falls.
- Reset asserted mid-instruction aborts it. Memory writes, register writes and PC writes in the cycle where `reset`=1 are suppressed.
- Cycles per instruction: load 5; store, R-type and I-type 4; branch, jal, jalr, lui 3; illegal 2.
- Memory is assumed to complete a read or write within one `clockCPU` cycle. No wait states.

## Test plan
- Reset: hold `reset` 2 cycles mid-EXEC_R → `estado`=0; all write enables are 0 while `reset`=1; FETCH is seen on the first cycle after release.
- R-type: opcode 0110011 → `estado` sequence 0,1,6,7,0. `EscreveReg`=1 only in state 7, with Mem2Reg=00.
- Load/store: opcode 0000011 gives sequence 0,1,2,3,4 with `IouD`=1 only in state 3. Opcode 0100011 gives 0,1,2,5 with `EscreveMem`=1 only in state 5.
- Branch: opcode 1100011 in state 8:
  - `funct3`=000, `Zero`=1 → `EscrevePC`=1.
  - `funct3`=000, `Zero`=0 → `EscrevePC`=0.
  - `funct3`=001, `Zero`=0 → `EscrevePC`=1.
- Jumps/LUI: jal → 0,1,9; jalr → 0,1,11; lui → 0,1,12. In 9 and 11, `EscrevePC`=1, `EscreveReg`=1 and Mem2Reg=10 in the same cycle.
- Illegal opcode 1111111 → `ilegal`=1 in DECODE, then `estado`=0. No write enable is asserted in DECODE.
